// File: rtl/pipe_adder_if.sv
// Operand/result stream bundle for pipe_adder.
// master = producer/consumer side, slave = the adder itself.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ov;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co, ov
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co, ov
    );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined add/sub: one SEG-bit segment per stage, carry registered between.
// Ports: clk, rstn (sync, active low), io (pipe_adder_if.slave stream).
module pipe_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic        clk,
    input  logic        rstn,
    pipe_adder_if.slave io
);
    localparam int STAGES = WIDTH / SEG;
    localparam int LAST   = STAGES - 1;

    // Stage k: sum bits below (k+1)*SEG are final; operand bits above
    // are still waiting for their stage.
    logic             r_vld [STAGES];
    logic             r_c   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic             r_ov;

    logic             w_rdy  [STAGES];
    logic             w_vin  [STAGES];
    logic             w_cin  [STAGES];
    logic             w_cout [STAGES];
    logic [WIDTH-1:0] w_ain  [STAGES];
    logic [WIDTH-1:0] w_bin  [STAGES];
    logic [WIDTH-1:0] w_sin  [STAGES];
    logic [WIDTH-1:0] w_snew [STAGES];
    logic [SEG:0]     w_seg  [STAGES];
    logic [WIDTH-1:0] w_bp;
    logic             w_c0;
    logic             w_chain;
    logic             w_ov;

    always_comb begin
        // Subtract as a + ~b + ~ci so co reads as "no borrow".
        w_bp = io.sub ? ~io.b : io.b;
        w_c0 = io.sub ? ~io.ci : io.ci;

        // A stage can load if it is empty or its successor drains.
        w_chain = io.out_ready;
        for (int k = LAST; k >= 0; k--) begin
            w_chain  = !r_vld[k] || w_chain;
            w_rdy[k] = w_chain;
        end

        w_vin[0] = io.in_valid;
        w_ain[0] = io.a;
        w_bin[0] = w_bp;
        w_cin[0] = w_c0;
        w_sin[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_vin[k] = r_vld[k-1];
            w_ain[k] = r_a[k-1];
            w_bin[k] = r_b[k-1];
            w_cin[k] = r_c[k-1];
            w_sin[k] = r_s[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            w_seg[k] = {1'b0, w_ain[k][k*SEG +: SEG]}
                     + {1'b0, w_bin[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, w_cin[k]};
            w_snew[k] = w_sin[k];
            w_snew[k][k*SEG +: SEG] = w_seg[k][SEG-1:0];
            w_cout[k] = w_seg[k][SEG];
        end

        // Same-sign operands giving an opposite-sign result.
        w_ov = (w_ain[LAST][WIDTH-1] == w_bin[LAST][WIDTH-1])
            && (w_snew[LAST][WIDTH-1] != w_ain[LAST][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ov <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_c[k]   <= 1'b0;
                r_s[k]   <= '0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_rdy[k]) begin
                    r_vld[k] <= w_vin[k];
                    if (w_vin[k]) begin
                        r_s[k] <= w_snew[k];
                        r_a[k] <= w_ain[k];
                        r_b[k] <= w_bin[k];
                        r_c[k] <= w_cout[k];
                    end
                end
            end
            if (w_rdy[LAST] && w_vin[LAST]) begin
                r_ov <= w_ov;
            end
        end
    end

    assign io.in_ready  = rstn && w_rdy[0];
    assign io.out_valid = r_vld[LAST];
    assign io.s         = r_s[LAST];
    assign io.co        = r_c[LAST];
    assign io.ov        = r_ov;
endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder: three configurations (32/8, 64/16, 16/16) share
// one clock and reset; results are scored against an arithmetic model.
module tb_pipe_adder;
    localparam int NC    = 3;
    localparam int CW [NC] = '{32, 64, 16};
    localparam int CS [NC] = '{8, 16, 16};
    localparam int NRAND = 1000;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        d_valid [NC];
    logic        d_ci    [NC];
    logic        d_sub   [NC];
    logic        d_ordy  [NC];
    logic [63:0] d_a     [NC];
    logic [63:0] d_b     [NC];
    logic        o_irdy  [NC];
    logic        o_vld   [NC];
    logic        o_co    [NC];
    logic        o_ov    [NC];
    logic [63:0] o_s     [NC];

    logic [65:0] q    [NC][$];
    logic [65:0] snap [NC];
    logic        hold [NC];
    logic        lacc [NC];
    int          acc  [NC];
    int          outs [NC];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_cfg
        localparam int W = CW[g];
        localparam int S = CS[g];
        pipe_adder_if #(.WIDTH(W)) ifc ();
        assign ifc.in_valid  = d_valid[g];
        assign ifc.a         = d_a[g][W-1:0];
        assign ifc.b         = d_b[g][W-1:0];
        assign ifc.ci        = d_ci[g];
        assign ifc.sub       = d_sub[g];
        assign ifc.out_ready = d_ordy[g];
        assign o_irdy[g]     = ifc.in_ready;
        assign o_vld[g]      = ifc.out_valid;
        assign o_s[g]        = 64'(ifc.s);
        assign o_co[g]       = ifc.co;
        assign o_ov[g]       = ifc.ov;
        pipe_adder #(.WIDTH(W), .SEG(S)) dut (
            .clk  (clk),
            .rstn (rstn),
            .io   (ifc)
        );
    end

    // {ov, co, s} from plain integer arithmetic on w-bit operands.
    function automatic logic [65:0] model(input int w,
                                          input logic [63:0] ai,
                                          input logic [63:0] bi,
                                          input logic ci,
                                          input logic sub);
        logic [63:0] mask, a, b, s;
        logic [65:0] t;
        logic co, ov;
        logic signed [67:0] lim, sa, sb, cs, r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = ai & mask;
        b = bi & mask;
        if (sub) begin
            t  = {2'b0, a} - {2'b0, b} - {65'd0, ci};
            co = ({2'b0, a} >= ({2'b0, b} + {65'd0, ci}));
        end else begin
            t  = {2'b0, a} + {2'b0, b} + {65'd0, ci};
            co = t[w];
        end
        s   = t[63:0] & mask;
        lim = 68'sd1 <<< (w - 1);
        sa  = $signed({4'd0, a});
        sb  = $signed({4'd0, b});
        if (a[w-1]) sa = sa - (lim <<< 1);
        if (b[w-1]) sb = sb - (lim <<< 1);
        cs = $signed({67'd0, ci});
        r  = sub ? (sa - sb - cs) : (sa + sb + cs);
        ov = (r >= lim) || (r < -lim);
        return {ov, co, s};
    endfunction

    function automatic logic [65:0] word(input int g);
        return {o_ov[g], o_co[g], o_s[g]};
    endfunction

    function automatic logic [63:0] pick();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = 64'h8000_8000_8000_8000;
            3:       v = 64'h7FFF_7FFF_7FFF_7FFF;
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs,
                       input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        for (int g = 0; g < NC; g++) begin
            d_valid[g] = 1'b0;
            d_ordy[g]  = 1'b1;
            d_a[g]     = '0;
            d_b[g]     = '0;
            d_ci[g]    = 1'b0;
            d_sub[g]   = 1'b0;
        end
    endtask

    task automatic clear_sb();
        for (int g = 0; g < NC; g++) begin
            q[g].delete();
            hold[g] = 1'b0;
            lacc[g] = 1'b0;
            acc[g]  = 0;
            outs[g] = 0;
        end
    endtask

    // Called at a falling edge with inputs already driven; scores the
    // transfers of the coming rising edge, then waits for the next fall.
    task automatic step();
        #1;
        for (int g = 0; g < NC; g++) begin
            if (hold[g]) begin
                chk("stall_vld", 66'(o_vld[g]), 66'd1);
                chk("stall_data", word(g), snap[g]);
            end
            if (o_vld[g] && d_ordy[g]) begin
                if (q[g].size() == 0)
                    chk("spurious", 66'(o_vld[g]), 66'd0);
                else
                    chk("result", word(g), q[g].pop_front());
                outs[g]++;
            end
            lacc[g] = d_valid[g] && o_irdy[g];
            if (lacc[g]) begin
                q[g].push_back(model(CW[g], d_a[g], d_b[g],
                                     d_ci[g], d_sub[g]));
                acc[g]++;
            end
            hold[g] = o_vld[g] && !d_ordy[g];
            snap[g] = word(g);
        end
        @(negedge clk);
    endtask

    task automatic directed(input int g, input logic [63:0] a,
                            input logic [63:0] b, input logic ci,
                            input logic sub, input logic [65:0] exp,
                            input int lat);
        int n;
        d_a[g]     = a;
        d_b[g]     = b;
        d_ci[g]    = ci;
        d_sub[g]   = sub;
        d_valid[g] = 1'b1;
        d_ordy[g]  = 1'b1;
        step();
        chk("dir_accept", 66'(lacc[g]), 66'd1);
        d_valid[g] = 1'b0;
        n = 1;
        while (!o_vld[g] && n < 20) begin
            step();
            n++;
        end
        chk("latency", 66'(n), 66'(lat));
        chk("directed", word(g), exp);
        step();
    endtask

    task automatic rand_drive(input int g);
        if (!(d_valid[g] && !lacc[g])) begin
            d_valid[g] = 1'($urandom_range(0, 1));
            d_a[g]     = pick();
            d_b[g]     = pick();
            d_ci[g]    = 1'($urandom_range(0, 1));
            d_sub[g]   = 1'($urandom_range(0, 1));
        end
        d_ordy[g] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int base;
        int cyc;
        idle();
        clear_sb();

        repeat (3) @(negedge clk);
        for (int g = 0; g < NC; g++) begin
            chk("rst_vld", 66'(o_vld[g]), 66'd0);
            chk("rst_out", word(g), 66'd0);
            chk("rst_irdy", 66'(o_irdy[g]), 66'd0);
        end
        rstn = 1'b1;
        #1;
        for (int g = 0; g < NC; g++)
            chk("rel_irdy", 66'(o_irdy[g]), 66'd1);
        @(negedge clk);

        directed(0, 64'hFFFF_FFFF, 64'h0, 1'b1, 1'b0,
                 {1'b0, 1'b1, 64'h0}, 4);
        directed(0, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0,
                 {1'b1, 1'b0, 64'h8000_0000}, 4);
        directed(0, 64'h8000_0000, 64'h1, 1'b0, 1'b1,
                 {1'b1, 1'b1, 64'h7FFF_FFFF}, 4);
        directed(0, 64'h5, 64'h7, 1'b0, 1'b1,
                 {1'b0, 1'b0, 64'hFFFF_FFFE}, 4);
        directed(0, 64'h7, 64'h5, 1'b1, 1'b1,
                 {1'b0, 1'b1, 64'h1}, 4);
        directed(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
                 {1'b0, 1'b1, 64'h0}, 4);
        directed(2, 64'hFFFF, 64'h0, 1'b1, 1'b0,
                 {1'b0, 1'b1, 64'h0}, 1);

        // Back-to-back burst: one word per cycle in and out.
        base = outs[0];
        for (int i = 0; i < 8; i++) begin
            d_valid[0] = 1'b1;
            d_a[0] = pick();
            d_b[0] = pick();
            d_ci[0] = 1'($urandom_range(0, 1));
            d_sub[0] = 1'($urandom_range(0, 1));
            step();
            chk("burst_acc", 66'(lacc[0]), 66'd1);
        end
        d_valid[0] = 1'b0;
        repeat (6) step();
        chk("burst_outs", 66'(outs[0] - base), 66'd8);

        // Fill with out_ready low; fifth word must wait.
        base = outs[0];
        d_ordy[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d_valid[0] = 1'b1;
            d_a[0] = pick();
            d_b[0] = pick();
            step();
            chk("fill_acc", 66'(lacc[0]), 66'd1);
        end
        d_a[0] = pick();
        d_b[0] = pick();
        step();
        chk("full_block", 66'(lacc[0]), 66'd0);
        step();
        chk("full_hold", 66'(lacc[0]), 66'd0);
        d_ordy[0] = 1'b1;
        step();
        chk("refill_acc", 66'(lacc[0]), 66'd1);
        d_valid[0] = 1'b0;
        repeat (6) step();
        chk("fill_outs", 66'(outs[0] - base), 66'd5);

        // Reset with three words in flight.
        d_ordy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d_valid[0] = 1'b1;
            d_a[0] = pick();
            d_b[0] = pick();
            step();
            chk("pre_rst_acc", 66'(lacc[0]), 66'd1);
        end
        d_valid[0] = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_vld", 66'(o_vld[0]), 66'd0);
        chk("mid_rst_out", word(0), 66'd0);
        chk("mid_rst_irdy", 66'(o_irdy[0]), 66'd0);
        rstn = 1'b1;
        clear_sb();
        idle();
        repeat (10) step();
        chk("no_stale", 66'(outs[0]), 66'd0);

        // Randomised traffic on all three configurations.
        clear_sb();
        cyc = 0;
        while ((acc[0] < NRAND || acc[1] < NRAND || acc[2] < NRAND)
               && cyc < 20000) begin
            for (int g = 0; g < NC; g++) rand_drive(g);
            step();
            cyc++;
        end
        for (int g = 0; g < NC; g++) begin
            d_valid[g] = 1'b0;
            d_ordy[g]  = 1'b1;
        end
        repeat (10) step();
        for (int g = 0; g < NC; g++) begin
            chk("rand_acc", 66'(acc[g] >= NRAND), 66'd1);
            chk("rand_drain", 66'(q[g].size()), 66'd0);
            chk("rand_count", 66'(outs[g]), 66'(acc[g]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined integer adder/subtractor: the next generation of the 32-bit ripple adder built from 8-bit segments. Operands of WIDTH bits are split into SEG-bit segments. Each segment is added in its own pipeline stage, and the carry is registered between stages. A valid/ready handshake on both sides gives full throughput and lossless backpressure. Adds subtract mode and signed-overflow detection. It sits in the datapath wherever a wide add/sub must close timing at the core clock.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SEG.
- SEG, 8, segment width per pipeline stage; STAGES = WIDTH/SEG (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous, active-low reset.
- in_valid  in  1  operand word offered.
- in_ready  out  1  stage 0 can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- s  out  WIDTH  result.
- co  out  1  carry-out (add) / NOT borrow-out (sub).
- ov  out  1  signed (two's-complement) overflow.

## Operation
- Effective operands: B' = sub ? ~b : b; C0 = sub ? ~ci : ci.
- Result: {co,s} = a + B' + C0.
  - add: a+b+ci.
  - sub: a−b−ci, with co=1 meaning no borrow.
- ov = (a[WIDTH-1] == B'[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]).
- Stage k (0..STAGES-1) holds a valid bit, the sum segments 0..k already computed, a registered carry out of segment k, and the unprocessed upper bits of a and B' plus the top-bit signs needed for ov.
- Stage k computes segment k from its upper-operand registers and the carry registered by stage k−1. Stage 0 uses C0.
- The last stage's registers drive s, co, ov and out_valid directly, with no combinational path from inputs.
- Handshake, per stage:
  - ready_k = !valid_k || ready_{k+1}, with ready_STAGES = out_ready.
  - in_ready = ready_0.
  - Stage k loads when ready_k: valid_k ← valid_{k−1}, or in_valid for k=0.
  - Data registers load only when ready_k && incoming valid; otherwise they hold.
- Transfers: an input transfer occurs when in_valid && in_ready; an output transfer when out_valid && out_ready.
- Results leave in acceptance order; none are dropped or duplicated.
- While out_valid && !out_ready, s/co/ov are stable and no stage with a valid word loses it.
- in_valid with in_ready=0 is ignored; the producer holds a/b/ci/sub.
- Simultaneous input and output transfer on a full pipeline is legal and sustains 1 word/cycle.
- STAGES=1 degenerates to a single registered adder with the same handshake.

## Timing
- Reset (rstn=0 at a clock edge): all valid bits 0, out_valid=0, s=0, co=0, ov=0. in_ready=0 while rstn=0; in_ready=1 on the first cycle after release.
- Reset mid-operation discards all in-flight words; no partial result is ever presented.
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+STAGES−1, i.e. STAGES cycles, with no stall.
- Throughput: 1 result/cycle while out_ready=1.
- Capacity: STAGES words in flight. in_ready falls in the same cycle out_ready falls only if all stages are valid.
- in_ready has a combinational path from out_ready (ready chain). All other outputs are registered.

## Test plan
Defaults WIDTH=32, SEG=8 unless stated.
- a=0xFFFFFFFF, b=0, ci=1, sub=0, out_ready=1 -> after 4 cycles s=0x00000000, co=1, ov=0. Carry ripples through all 4 stages.
- a=0x7FFFFFFF, b=1, ci=0, sub=0 -> s=0x80000000, co=0, ov=1. a=0x80000000, b=1, ci=0, sub=1 -> s=0x7FFFFFFF, co=1, ov=1.
- a=5, b=7, ci=0, sub=1 -> s=0xFFFFFFFE, co=0, ov=0. a=7, b=5, ci=1, sub=1 -> s=0x00000001, co=1, ov=0.
- 1000 random back-to-back words with in_valid and out_ready each randomly toggled (50%) -> every output matches the reference model in order. s/co/ov are stable during stalls; no loss or duplication.
- Fill the pipeline (4 words, out_ready=0) -> in_ready=0 and the 5th word is not accepted. Raise out_ready -> all 5 words emerge in order.
- Assert rstn=0 for 1 cycle with 3 words in flight -> out_valid=0, s/co/ov=0, and no stale word appears afterwards. Repeat the random test with WIDTH=64, SEG=16 (latency 4) and WIDTH=16, SEG=16 (latency 1).
